vsd_stim_seq: RTL



---
 rtl/vsd_stim_seq.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/vsd_stim_seq.sv
// Power-up stimulus sequencer: delay, SoC reset pulse, enable ramp, then counted reference-clock run.
// Optional per-reload period jitter from an 8-bit LFSR when STIM_JITTER_EN is defined.
//
// state  | meaning
// IDLE   | outputs at rest, waiting for start
// WAIT   | counting RST_DLY cycles before the SoC reset pulse
// RST    | soc_reset high for RST_LEN cycles
// EN_VCO | VCO enabled, charge pump still off (one cycle)
// RUN    | all channels toggling until RUN_TOGGLES channel-0 toggles
// DONE   | outputs held, done sticky, start restarts
module vsd_stim_seq #(
    parameter int NCH         = 2,
    parameter int DIVW        = 8,
    parameter int RST_DLY     = 20,
    parameter int RST_LEN     = 100,
    parameter int RUN_TOGGLES = 600,
    parameter int CNTW        = 16
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NCH*DIVW-1:0]  half_per,
    output logic [NCH-1:0]       ref_out,
    output logic                 soc_reset,
    output logic                 ENb_CP,
    output logic                 ENb_VCO,
    output logic                 busy,
    output logic                 done,
    output logic [CNTW-1:0]      toggle_cnt
);
    typedef enum logic [2:0] {IDLE, WAIT, RST, EN_VCO, RUN, DONE} state_t;

    localparam int DLYW = $clog2((RST_DLY > RST_LEN ? RST_DLY : RST_LEN) + 1);
    localparam logic [DIVW:0] CNT_ONE = (DIVW+1)'(1);

    state_t          state;
    logic [DLYW-1:0] dly;
    logic [DIVW-1:0] hp_q [NCH];
    logic [DIVW:0]   cnt  [NCH];
    logic            jit;

`ifdef STIM_JITTER_EN
    logic [7:0] lfsr;
    assign jit = lfsr[0];
`else
    assign jit = 1'b0;
`endif

    // A programmed half-period of zero behaves as one cycle.
    function automatic logic [DIVW:0] hp_eff(input logic [DIVW-1:0] hp);
        return (hp == '0) ? CNT_ONE : {1'b0, hp};
    endfunction

    always_ff @(posedge CLK) begin
        if (reset) begin
            state      <= IDLE;
            dly        <= '0;
            ref_out    <= '0;
            soc_reset  <= 1'b0;
            ENb_CP     <= 1'b1;
            ENb_VCO    <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            toggle_cnt <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt[i]  <= '0;
                hp_q[i] <= '0;
            end
`ifdef STIM_JITTER_EN
            lfsr <= 8'hA5;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= WAIT;
                        dly        <= DLYW'(RST_DLY - 1);
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        ref_out    <= '0;
                        toggle_cnt <= '0;
                        ENb_CP     <= 1'b1;
                        ENb_VCO    <= 1'b1;
                    end
                end
                WAIT: begin
                    if (dly == '0) begin
                        state     <= RST;
                        dly       <= DLYW'(RST_LEN - 1);
                        soc_reset <= 1'b1;
                    end else begin
                        dly <= dly - DLYW'(1);
                    end
                end
                RST: begin
                    if (dly == '0) begin
                        state     <= EN_VCO;
                        soc_reset <= 1'b0;
                        ENb_VCO   <= 1'b0;
                    end else begin
                        dly <= dly - DLYW'(1);
                    end
                end
                EN_VCO: begin
                    state  <= RUN;
                    ENb_CP <= 1'b0;
                    for (int i = 0; i < NCH; i++) begin
                        hp_q[i] <= half_per[i*DIVW +: DIVW];
                        cnt[i]  <= hp_eff(half_per[i*DIVW +: DIVW]);
                    end
`ifdef STIM_JITTER_EN
                    lfsr <= 8'hA5;
`endif
                end
                RUN: begin
                    if (toggle_cnt == CNTW'(RUN_TOGGLES)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        // Reloads use the LFSR value from before this cycle's advance.
                        for (int i = 0; i < NCH; i++) begin
                            if (cnt[i] == CNT_ONE) begin
                                ref_out[i] <= ~ref_out[i];
                                cnt[i]     <= hp_eff(hp_q[i]) + {{DIVW{1'b0}}, jit};
                            end else begin
                                cnt[i] <= cnt[i] - CNT_ONE;
                            end
                        end
                        if (cnt[0] == CNT_ONE) begin
                            toggle_cnt <= toggle_cnt + CNTW'(1);
`ifdef STIM_JITTER_EN
                            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
